parity_frame_rx: RTL and testbench

Serial frame receiver and parity checker. It is the receiving end of the even-parity bit generated across an 8-bit data word. The block deserializes start / data / parity / stop frames from a single-bit line, recomputes parity over the received word and flags parity and framing errors. It sits between the line sampler, which supplies a one-cycle `bit_en` strobe per bit period, and the consuming logic, which accepts a one-cycle `valid` pulse per frame.

---
 rtl/parity_frame_rx.sv | 110 +++++++++++
 tb/tb_parity_frame_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_rx.sv
// Serial start/data/parity/stop frame receiver with parity and framing checks.
// Bits are taken only on bit_en strobes; each completed frame yields a one-cycle valid pulse.
module parity_frame_rx #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              bit_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              par_bit;
    logic              last_bit;
    logic              frame_done;
    logic              par_fail;

    assign last_bit   = (bit_cnt == CNT_W'(DATA_W - 1));
    assign frame_done = bit_en && (state == STOP);
    assign par_fail   = (^shift) ^ par_bit ^ ODD;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bit_en) begin
            case (state)
                IDLE:    if (!rx) state_next = DATA;
                DATA:    if (last_bit) state_next = PARITY;
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shift      <= '0;
            par_bit    <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (bit_en) begin
                case (state)
                    IDLE: begin
                        if (!rx) bit_cnt <= '0;
                    end
                    DATA: begin
                        shift[bit_cnt] <= rx;
                        bit_cnt        <= bit_cnt + 1'b1;
                    end
                    PARITY: begin
                        par_bit <= rx;
                    end
                    STOP: begin
                        data_out   <= shift;
                        parity_err <= par_fail;
                        frame_err  <= ~rx;
                        valid      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Clear has priority over a same-cycle increment; the count sticks at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (frame_done && par_fail && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Self-checking bench for parity_frame_rx: table-driven frames, corner sequences and random frames
// checked against a popcount-based reference for parity and a saturating error counter.
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       bit_en = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] data_out, data_out_o, err_cnt, err_cnt_o;
    logic       valid, parity_err, frame_err, busy;
    logic       valid_o, parity_err_o, frame_err_o, busy_o;

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(8), .ODD(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .bit_en     (bit_en),
        .clr_err    (clr_err),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy),
        .err_cnt    (err_cnt)
    );

    parity_frame_rx #(.DATA_W(8), .ODD(1'b1)) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .bit_en     (bit_en),
        .clr_err    (clr_err),
        .data_out   (data_out_o),
        .valid      (valid_o),
        .parity_err (parity_err_o),
        .frame_err  (frame_err_o),
        .busy       (busy_o),
        .err_cnt    (err_cnt_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int vcount = 0;
    int busy_bad = 0;
    int model_err = 0;
    bit track_busy = 1'b0;

    always @(posedge clk) if (valid) vcount++;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        int         max_gap;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_pe_odd;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic b, input logic en);
        rx = b;
        bit_en = en;
        @(posedge clk);
        #1;
        if (track_busy && busy !== 1'b1) busy_bad++;
    endtask

    task automatic gap(input int max_gap);
        int n;
        n = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        for (int i = 0; i < n; i++) tick(logic'($urandom & 1), 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int max_gap, input bit clr_at_stop);
        track_busy = 1'b1;
        tick(1'b0, 1'b1);
        gap(max_gap);
        for (int i = 0; i < 8; i++) begin
            tick(d[i], 1'b1);
            gap(max_gap);
        end
        tick(p, 1'b1);
        gap(max_gap);
        track_busy = 1'b0;
        clr_err = clr_at_stop;
        tick(s, 1'b1);
        clr_err = 1'b0;
    endtask

    function automatic int ref_pe(input logic [7:0] d, input logic p, input int odd);
        return ($countones(d) + int'(p) + odd) % 2;
    endfunction

    task automatic check_frame(input string name, input logic [7:0] d, input logic p,
                               input logic s, input bit clr);
        int pe;
        pe = ref_pe(d, p, 0);
        if (clr) model_err = 0;
        else if (pe == 1 && model_err < 255) model_err++;
        check({name, ".valid"}, int'(valid), 1);
        check({name, ".data"}, int'(data_out), int'(d));
        check({name, ".parity_err"}, int'(parity_err), pe);
        check({name, ".frame_err"}, int'(frame_err), int'(!s));
        check({name, ".parity_err_odd"}, int'(parity_err_o), ref_pe(d, p, 1));
        check({name, ".err_cnt"}, int'(err_cnt), model_err);
    endtask

    initial begin
        int v0;
        logic [7:0] d;
        logic p, s;

        vecs[0] = '{d: 8'hA5, p: 1'b0, s: 1'b1, max_gap: 0, exp_pe: 1'b0, exp_fe: 1'b0, exp_pe_odd: 1'b1};
        vecs[1] = '{d: 8'h07, p: 1'b0, s: 1'b1, max_gap: 0, exp_pe: 1'b1, exp_fe: 1'b0, exp_pe_odd: 1'b0};
        vecs[2] = '{d: 8'h3C, p: 1'b0, s: 1'b0, max_gap: 0, exp_pe: 1'b0, exp_fe: 1'b1, exp_pe_odd: 1'b1};
        vecs[3] = '{d: 8'h81, p: 1'b0, s: 1'b1, max_gap: 3, exp_pe: 1'b0, exp_fe: 1'b0, exp_pe_odd: 1'b1};
        vecs[4] = '{d: 8'h01, p: 1'b1, s: 1'b1, max_gap: 2, exp_pe: 1'b0, exp_fe: 1'b0, exp_pe_odd: 1'b1};
        vecs[5] = '{d: 8'hFF, p: 1'b1, s: 1'b1, max_gap: 0, exp_pe: 1'b1, exp_fe: 1'b0, exp_pe_odd: 1'b0};

        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        check("reset.data", int'(data_out), 0);
        check("reset.valid", int'(valid), 0);
        check("reset.busy", int'(busy), 0);
        check("reset.err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);

        foreach (vecs[k]) begin
            v0 = vcount;
            busy_bad = 0;
            send_frame(vecs[k].d, vecs[k].p, vecs[k].s, vecs[k].max_gap, 1'b0);
            if (vecs[k].exp_pe && model_err < 255) model_err++;
            check($sformatf("vec%0d.valid", k), int'(valid), 1);
            check($sformatf("vec%0d.data", k), int'(data_out), int'(vecs[k].d));
            check($sformatf("vec%0d.parity_err", k), int'(parity_err), int'(vecs[k].exp_pe));
            check($sformatf("vec%0d.frame_err", k), int'(frame_err), int'(vecs[k].exp_fe));
            check($sformatf("vec%0d.parity_err_odd", k), int'(parity_err_o), int'(vecs[k].exp_pe_odd));
            check($sformatf("vec%0d.err_cnt", k), int'(err_cnt), model_err);
            check($sformatf("vec%0d.busy_during", k), busy_bad, 0);
            tick(1'b1, 1'b1);
            check($sformatf("vec%0d.valid_width", k), int'(valid), 0);
            tick(1'b1, 1'b1);
            check($sformatf("vec%0d.valid_count", k), vcount - v0, 1);
            check($sformatf("vec%0d.idle", k), int'(busy), 0);
        end

        // Reset in the middle of the data field, then a clean frame.
        tick(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
        check("midrst.busy_before", int'(busy), 1);
        v0 = vcount;
        rst_n = 1'b0;
        #1;
        check("midrst.data", int'(data_out), 0);
        check("midrst.parity_err", int'(parity_err), 0);
        check("midrst.frame_err", int'(frame_err), 0);
        check("midrst.busy", int'(busy), 0);
        check("midrst.err_cnt", int'(err_cnt), 0);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b1);
        check("midrst.valid_held", int'(valid), 0);
        check("midrst.busy_held", int'(busy), 0);
        rst_n = 1'b1;
        model_err = 0;
        tick(1'b1, 1'b1);
        send_frame(8'h55, 1'b0, 1'b1, 0, 1'b0);
        check_frame("resume", 8'h55, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        check("resume.valid_count", vcount - v0, 1);

        for (int w = 0; w < 256; w++) begin
            d = 8'(w);
            send_frame(d, ^d, 1'b1, 0, 1'b0);
            check_frame("sweep", d, ^d, 1'b1, 1'b0);
        end
        check("sweep.err_cnt", int'(err_cnt), 0);

        for (int n = 0; n < 300; n++) begin
            d = 8'($urandom);
            send_frame(d, ~(^d), 1'b1, 0, 1'b0);
            check_frame("sat", d, ~(^d), 1'b1, 1'b0);
        end
        check("sat.err_cnt", int'(err_cnt), 255);

        send_frame(8'h07, 1'b0, 1'b1, 0, 1'b1);
        check_frame("clr_vs_inc", 8'h07, 1'b0, 1'b1, 1'b1);
        check("clr_vs_inc.err_cnt", int'(err_cnt), 0);
        tick(1'b1, 1'b1);

        for (int n = 0; n < 40; n++) begin
            d = 8'($urandom);
            p = logic'($urandom & 1);
            s = logic'(($urandom % 4) != 0);
            send_frame(d, p, s, 3, 1'b0);
            check_frame("rand", d, p, s, 1'b0);
            tick(1'b1, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
